// File: rtl/usb3_rx_descram_align_if.sv
// Symbol bus between the PIPE RX side and the link-layer framer side of
// usb3_rx_descram_align: raw input lanes in, descrambled packed lanes out.
interface usb3_rx_descram_align_if #(
  parameter int NSYM = 4
) ();
  logic              in_valid;
  logic [8*NSYM-1:0] in_data;
  logic [NSYM-1:0]   in_datak;
  logic              out_valid;
  logic [8*NSYM-1:0] out_data;
  logic [NSYM-1:0]   out_datak;

  // Upstream PIPE receiver view.
  modport master (
    output in_valid, in_data, in_datak,
    input  out_valid, out_data, out_datak
  );

  // Conditioner view.
  modport slave (
    input  in_valid, in_data, in_datak,
    output out_valid, out_data, out_datak
  );
endinterface

// File: rtl/usb3_rx_descram_align.sv
// USB 3.0 RX symbol conditioner: SKP removal, re-packing, per-symbol descrambling.
// Optional macro USB3_RX_SKP_STATS_EN adds a saturating SKP removal counter.
module usb3_rx_descram_align #(
  parameter int          NSYM      = 4,
  parameter int          ACC_SYM   = 2 * NSYM,
  parameter logic [7:0]  SKP_SYM   = 8'h3C,
  parameter logic [7:0]  COM_SYM   = 8'hBC,
  parameter logic [15:0] LFSR_SEED = 16'hFFFF
) (
  input  logic                   local_clk,
  input  logic                   reset_n,
  input  logic                   enable,
  usb3_rx_descram_align_if.slave bus,
  output logic                   err_overflow,
  output logic                   err_skp_split
`ifdef USB3_RX_SKP_STATS_EN
  ,
  input  logic                   skp_count_clr,
  output logic [15:0]            skp_count
`endif
);

  localparam int CNT_W   = $clog2(NSYM + 1);
  localparam int DEPTH_W = $clog2(ACC_SYM + 1);
  localparam int SUM_W   = $clog2(ACC_SYM + NSYM + 1);

  typedef struct packed {
    logic       k;
    logic [7:0] d;
  } sym_t;

  // ---------------------------------------------------------------
  // Stage 1: SKP detection and compaction toward lane 0
  // ---------------------------------------------------------------
  sym_t [NSYM-1:0]  in_sym;
  logic [NSYM-1:0]  skp;
  logic [NSYM-1:0]  keep;
  logic [CNT_W-1:0] rank [NSYM];
  logic [CNT_W-1:0] cmp_cnt;
  logic [CNT_W-1:0] skp_starts;
  logic             skp_prev;
  sym_t [NSYM-1:0]  cmp_sym;

  sym_t [NSYM-1:0]  s1_sym;
  logic [CNT_W-1:0] s1_cnt;

  always_comb begin
    for (int i = 0; i < NSYM; i++) begin
      in_sym[i] = {bus.in_datak[i], bus.in_data[8*i +: 8]};
      skp[i]    = bus.in_valid && bus.in_datak[i] && (bus.in_data[8*i +: 8] == SKP_SYM);
    end
  end

  // NOTE: every combinational output gets a default before the loop, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    keep       = bus.in_valid ? ~skp : '0;
    cmp_cnt    = '0;
    skp_starts = '0;
    skp_prev   = 1'b0;
    for (int i = 0; i < NSYM; i++) begin
      rank[i] = cmp_cnt;
      if (keep[i]) cmp_cnt = cmp_cnt + CNT_W'(1);
      if (skp[i] && !skp_prev) skp_starts = skp_starts + CNT_W'(1);
      skp_prev = skp[i];
    end
  end

  // Output lane j takes the kept input lane with exactly j kept lanes below it.
  always_comb begin
    cmp_sym = '0;
    for (int j = 0; j < NSYM; j++) begin
      for (int i = 0; i < NSYM; i++) begin
        if (keep[i] && (rank[i] == CNT_W'(j))) cmp_sym[j] = in_sym[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking is reserved for always_comb temporaries.
  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      s1_sym        <= '0;
      s1_cnt        <= '0;
      err_skp_split <= 1'b0;
    end else begin
      s1_sym <= cmp_sym;
      s1_cnt <= cmp_cnt;
      if (skp_starts > CNT_W'(1)) err_skp_split <= 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: accumulator (append, then pop a full word when available)
  // ---------------------------------------------------------------
  sym_t [ACC_SYM-1:0]      acc_mem;
  sym_t [ACC_SYM-1:0]      acc_nxt;
  logic [DEPTH_W-1:0]      acc_depth;
  logic [DEPTH_W-1:0]      depth_nxt;
  sym_t [ACC_SYM+NSYM-1:0] ext;
  logic [SUM_W-1:0]        total;
  logic [SUM_W-1:0]        remain;
  logic                    pop;
  logic                    ovf;

  sym_t [NSYM-1:0]         s2_sym;
  logic                    s2_valid;

  always_comb begin
    ext = '0;
    for (int j = 0; j < ACC_SYM; j++) begin
      if (SUM_W'(j) < SUM_W'(acc_depth)) ext[j] = acc_mem[j];
    end
    for (int m = 0; m < NSYM; m++) begin
      for (int j = 0; j < ACC_SYM + NSYM; j++) begin
        if ((SUM_W'(m) < SUM_W'(s1_cnt)) &&
            (SUM_W'(j) == SUM_W'(acc_depth) + SUM_W'(m))) ext[j] = s1_sym[m];
      end
    end
  end

  always_comb begin
    total     = SUM_W'(acc_depth) + SUM_W'(s1_cnt);
    pop       = (total >= SUM_W'(NSYM));
    remain    = pop ? (total - SUM_W'(NSYM)) : total;
    ovf       = (remain > SUM_W'(ACC_SYM));
    depth_nxt = ovf ? DEPTH_W'(ACC_SYM) : DEPTH_W'(remain);
    // Slots past ACC_SYM fall off the top: the newest symbols are the ones lost.
    for (int j = 0; j < ACC_SYM; j++) begin
      acc_nxt[j] = pop ? ext[j + NSYM] : ext[j];
    end
  end

  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      acc_depth    <= '0;
      s2_valid     <= 1'b0;
      s2_sym       <= '0;
      err_overflow <= 1'b0;
    end else begin
      acc_depth <= depth_nxt;
      s2_valid  <= pop;
      s2_sym    <= ext[NSYM-1:0];
      if (ovf) err_overflow <= 1'b1;
    end
  end

  // NOTE: the accumulator storage is deliberately not reset; slots at or above
  // acc_depth are never read, so clearing depth alone flushes stale symbols.
  always_ff @(posedge local_clk) begin
    acc_mem <= acc_nxt;
  end

  // ---------------------------------------------------------------
  // Stage 3: descrambler, x^16+x^5+x^4+x^3+1 Galois LFSR, 8 bits per symbol
  // ---------------------------------------------------------------
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_cur;
  logic [15:0]       lfsr_adv;
  logic [7:0]        ks_byte;
  logic [8*NSYM-1:0] s3_data;
  logic [NSYM-1:0]   s3_k;

  // Returns {next_state, key_byte}; key bit 0 is the first bit on the wire.
  function automatic logic [23:0] lfsr_byte(input logic [15:0] s);
    logic [15:0] st;
    logic [7:0]  key;
    st = s;
    for (int b = 0; b < 8; b++) begin
      key[b] = st[15];
      st     = {st[14:0], 1'b0} ^ (st[15] ? 16'h0039 : 16'h0000);
    end
    return {st, key};
  endfunction

  always_comb begin
    lfsr_cur = lfsr;
    lfsr_adv = '0;
    ks_byte  = '0;
    s3_data  = '0;
    s3_k     = '0;
    for (int i = 0; i < NSYM; i++) begin
      {lfsr_adv, ks_byte} = lfsr_byte(lfsr_cur);
      s3_k[i] = s2_sym[i].k;
      if (s2_sym[i].k) begin
        // K symbols pass in clear but still consume keystream; COM re-seeds.
        s3_data[8*i +: 8] = s2_sym[i].d;
        lfsr_cur          = (s2_sym[i].d == COM_SYM) ? LFSR_SEED : lfsr_adv;
      end else begin
        s3_data[8*i +: 8] = enable ? (s2_sym[i].d ^ ks_byte) : s2_sym[i].d;
        lfsr_cur          = lfsr_adv;
      end
    end
  end

  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      lfsr          <= LFSR_SEED;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_datak <= '0;
    end else if (s2_valid) begin
      lfsr          <= lfsr_cur;
      bus.out_valid <= 1'b1;
      bus.out_data  <= s3_data;
      bus.out_datak <= s3_k;
    end else begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_datak <= '0;
    end
  end

`ifdef USB3_RX_SKP_STATS_EN
  // ---------------------------------------------------------------
  // Optional SKP removal statistics (saturating)
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] skp_cnt;
  logic [16:0]      skp_sum;

  always_comb begin
    skp_cnt = '0;
    for (int i = 0; i < NSYM; i++) begin
      if (skp[i]) skp_cnt = skp_cnt + CNT_W'(1);
    end
    skp_sum = {1'b0, skp_count} + 17'(skp_cnt);
  end

  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      skp_count <= '0;
    end else if (skp_count_clr) begin
      skp_count <= '0;
    end else begin
      skp_count <= skp_sum[16] ? 16'hFFFF : skp_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_usb3_rx_descram_align.sv
// Directed self-checking bench for usb3_rx_descram_align (NSYM=4, ACC_SYM=8).
// Keystream anchors: after COM the first four key bytes are FF 17 C0 14.
module tb_usb3_rx_descram_align;

  localparam int          NSYM = 4;
  localparam logic [31:0] COM4 = 32'hBCBCBCBC;

  logic local_clk = 1'b0;
  logic reset_n;
  logic enable;
  logic err_overflow;
  logic err_skp_split;
`ifdef USB3_RX_SKP_STATS_EN
  logic        skp_count_clr;
  logic [15:0] skp_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] tb_lfsr;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;

  usb3_rx_descram_align_if #(.NSYM(NSYM)) bus ();

  usb3_rx_descram_align #(.NSYM(NSYM)) dut (
    .local_clk     (local_clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .bus           (bus),
    .err_overflow  (err_overflow),
    .err_skp_split (err_skp_split)
`ifdef USB3_RX_SKP_STATS_EN
    ,
    .skp_count_clr (skp_count_clr),
    .skp_count     (skp_count)
`endif
  );

  always #5 local_clk = ~local_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one input word, let one edge pass, settle 1 time unit past it.
  task automatic tick(input logic v, input logic [31:0] d, input logic [3:0] k);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_datak = k;
    @(posedge local_clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 32'h0, 4'h0);
  endtask

  // Scrambler used only to build stimulus.
  function automatic logic [7:0] key_byte();
    logic [7:0] kb;
    for (int b = 0; b < 8; b++) begin
      kb[b]   = tb_lfsr[15];
      tb_lfsr = {tb_lfsr[14:0], 1'b0} ^ (tb_lfsr[15] ? 16'h0039 : 16'h0000);
    end
    return kb;
  endfunction

  function automatic logic [31:0] scr_word(input logic [31:0] plain);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = plain[8*i +: 8] ^ key_byte();
    return w;
  endfunction

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_datak = '0;
`ifdef USB3_RX_SKP_STATS_EN
    skp_count_clr = 1'b0;
`endif

    // Reset state
    idle();
    idle();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_out_datak", bus.out_datak, 4'h0);
    check("rst_err_overflow", err_overflow, 1'b0);
    check("rst_err_skp_split", err_skp_split, 1'b0);
    reset_n = 1'b1;

    // Known keystream: COM x4 then raw zeros decode to FF 17 C0 14
    tick(1'b1, COM4, 4'hF);
    tick(1'b1, 32'h0, 4'h0);
    check("t0_not_early", bus.out_valid, 1'b0);
    idle();
    check("t0_com_valid", bus.out_valid, 1'b1);
    check("t0_com_data", bus.out_data, COM4);
    check("t0_com_datak", bus.out_datak, 4'hF);
    idle();
    check("t0_key_valid", bus.out_valid, 1'b1);
    check("t0_key_data", bus.out_data, 32'h14C017FF);
    check("t0_key_datak", bus.out_datak, 4'h0);
    idle();
    check("t0_drained_valid", bus.out_valid, 1'b0);
    check("t0_drained_data", bus.out_data, 32'h0);

    // Test 1: COM x4 then 8 scrambled zero words
    tb_lfsr = 16'hFFFF;
    tick(1'b1, COM4, 4'hF);
    for (int w = 0; w < 8; w++) begin
      tick(1'b1, scr_word(32'h0), 4'h0);
      if (w == 0) begin
        check("t1_no_early_valid", bus.out_valid, 1'b0);
      end else if (w == 1) begin
        check("t1_com_valid", bus.out_valid, 1'b1);
        check("t1_com_datak", bus.out_datak, 4'hF);
      end else begin
        check("t1_valid", bus.out_valid, 1'b1);
        check("t1_zero", bus.out_data, 32'h0);
      end
    end
    for (int w = 0; w < 2; w++) begin
      idle();
      check("t1_tail_valid", bus.out_valid, 1'b1);
      check("t1_tail_zero", bus.out_data, 32'h0);
    end
    idle();
    check("t1_end_valid", bus.out_valid, 1'b0);
    check("t1_err_overflow", err_overflow, 1'b0);
    check("t1_err_skp_split", err_skp_split, 1'b0);

    // Test 3: COM on lane 2 only; lane 3 onward use the seed
    tb_lfsr = 16'hFFFF;
    void'(key_byte());
    tick(1'b1, 32'hFFBC0000, 4'b0100);
    tick(1'b1, scr_word(32'h0), 4'h0);
    tick(1'b1, scr_word(32'h0), 4'h0);
    check("t3_valid", bus.out_valid, 1'b1);
    check("t3_lanes23", bus.out_data & 32'hFFFF0000, 32'h00BC0000);
    check("t3_datak", bus.out_datak, 4'b0100);
    idle();
    check("t3_word1", bus.out_data, 32'h0);
    idle();
    check("t3_word2", bus.out_data, 32'h0);
    check("t3_word2_valid", bus.out_valid, 1'b1);
    idle();
    check("t3_end_valid", bus.out_valid, 1'b0);

    // Test 2: contiguous SKP at lanes 1,2 in two words, raw pass-through
    enable = 1'b0;
    tick(1'b1, 32'hAA3C3C55, 4'b0110);
    tick(1'b1, 32'h04030201, 4'h0);
    tick(1'b1, 32'h883C3C77, 4'b0110);
    check("t2_gap", bus.out_valid, 1'b0);
    tick(1'b1, 32'h0D0C0B0A, 4'h0);
    check("t2_w0_valid", bus.out_valid, 1'b1);
    check("t2_w0_data", bus.out_data, 32'h0201AA55);
    check("t2_w0_datak", bus.out_datak, 4'h0);
    idle();
    check("t2_w1_valid", bus.out_valid, 1'b1);
    check("t2_w1_data", bus.out_data, 32'h88770403);
    idle();
    check("t2_w2_valid", bus.out_valid, 1'b1);
    check("t2_w2_data", bus.out_data, 32'h0D0C0B0A);
    idle();
    check("t2_end_valid", bus.out_valid, 1'b0);
    check("t2_err_skp_split", err_skp_split, 1'b0);

    // Test 4: split SKP at lanes 0 and 2
    tick(1'b1, 32'h443C223C, 4'b0101);
    check("t4_split_set", err_skp_split, 1'b1);
    tick(1'b1, 32'h88776655, 4'h0);
    tick(1'b1, 32'h993CAA3C, 4'b0101);
    check("t4_gap", bus.out_valid, 1'b0);
    idle();
    check("t4_w0_valid", bus.out_valid, 1'b1);
    check("t4_w0_data", bus.out_data, 32'h66554422);
    idle();
    check("t4_w1_valid", bus.out_valid, 1'b1);
    check("t4_w1_data", bus.out_data, 32'h99AA8877);
    idle();
    check("t4_end_valid", bus.out_valid, 1'b0);
    check("t4_split_sticky", err_skp_split, 1'b1);

    // Test 5: enable=0 passes scrambled data raw, LFSR keeps tracking
    p0 = 32'h33221100;
    p1 = 32'h77665544;
    p2 = 32'hBBAA9988;
    p3 = 32'hFFEEDDCC;
    tb_lfsr = 16'hFFFF;
    w0 = scr_word(p0);
    w1 = scr_word(p1);
    w2 = scr_word(p2);
    w3 = scr_word(p3);
    tick(1'b1, COM4, 4'hF);
    tick(1'b1, w0, 4'h0);
    tick(1'b1, w1, 4'h0);
    check("t5_com_data", bus.out_data, COM4);
    idle();
    check("t5_raw0", bus.out_data, w0);
    idle();
    check("t5_raw1", bus.out_data, w1);
    idle();
    check("t5_gap_valid", bus.out_valid, 1'b0);
    enable = 1'b1;
    tick(1'b1, w2, 4'h0);
    tick(1'b1, w3, 4'h0);
    idle();
    check("t5_plain2_valid", bus.out_valid, 1'b1);
    check("t5_plain2", bus.out_data, p2);
    idle();
    check("t5_plain3", bus.out_data, p3);
    idle();
    check("t5_end_valid", bus.out_valid, 1'b0);

    // Test 6: reset with 3 symbols buffered discards them
    enable = 1'b0;
    tick(1'b1, 32'h3322113C, 4'b0001);
    idle();
    check("t6_buffered_no_valid", bus.out_valid, 1'b0);
    reset_n = 1'b0;
    idle();
    check("t6_rst_valid", bus.out_valid, 1'b0);
    check("t6_rst_data", bus.out_data, 32'h0);
    check("t6_rst_split_clear", err_skp_split, 1'b0);
    reset_n = 1'b1;
    tick(1'b1, 32'hDDCCBBAA, 4'h0);
    check("t6_post_no_early", bus.out_valid, 1'b0);
    idle();
    idle();
    check("t6_fresh_valid", bus.out_valid, 1'b1);
    check("t6_fresh_data", bus.out_data, 32'hDDCCBBAA);
    idle();
    check("t6_no_stale_valid", bus.out_valid, 1'b0);
    check("t6_no_stale_data", bus.out_data, 32'h0);
    check("t6_err_overflow", err_overflow, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb3_rx_descram_align.md
Name: usb3_rx_descram_align

Overview:
Parametrised USB 3.0 RX symbol conditioner between the PIPE RX interface and the link-layer framer.
- Removes SKP ordered-set symbols at any position and in any pattern.
- Re-packs the surviving symbols into full NSYM-wide words.
- Descrambles data symbols with a per-symbol LFSR that re-seeds at every COM, whatever lane the COM lands on.
- Generalises the fixed 4-symbol design to 1/2/4-symbol datapaths. Adds overflow detection and per-lane COM alignment without restrictions.

Parameters:
NSYM, 4, symbols per clock (1, 2 or 4); datapath width = 8*NSYM
ACC_SYM, 2*NSYM, accumulator capacity in symbols (min 2*NSYM)
SKP_SYM, 8'h3C, K-code removed from stream (K28.1)
COM_SYM, 8'hBC, K-code that re-seeds LFSR (K28.5)
LFSR_SEED, 16'hFFFF, LFSR value applied to the first symbol after COM

Ports:
local_clk  in  1  clock
reset_n  in  1  synchronous active-low reset
enable  in  1  1 = descramble data symbols; 0 = pass through unscrambled (LFSR still tracks)
in_valid  in  1  input word qualifier
in_data  in  8*NSYM  raw symbols, lane 0 = [7:0] = oldest
in_datak  in  NSYM  K-flag per lane
out_data  out  8*NSYM  descrambled symbols, lane 0 oldest
out_datak  out  NSYM  K-flag per lane
out_valid  out  1  out_data holds NSYM new symbols
err_overflow  out  1  sticky: accumulator would exceed ACC_SYM
err_skp_split  out  1  sticky: SKP lanes in one word are not contiguous

Behaviour:
Interface and reset
- Clock local_clk; reset reset_n, synchronous, active-low.
- Reset values: out_data=0, out_datak=0, out_valid=0, err_*=0, accumulator depth=0, LFSR=LFSR_SEED.
- Reset mid-stream discards all buffered symbols. The next COM is required before descrambled output is meaningful.

Stage 1 (registered): compaction
- A lane is a SKP lane when in_datak[i] and the symbol equals SKP_SYM.
- Non-SKP lanes are packed toward lane 0 in order; count n = NSYM - popcount(skp).
- Any SKP pattern is handled correctly.
- err_skp_split is set when the SKP lanes are not one contiguous run. Data is still compacted.
- in_valid=0 gives n=0.

Stage 2 (registered): accumulator
- Shift register of ACC_SYM symbols plus depth counter, width clog2(ACC_SYM+1).
- Each cycle: appends n symbols. If depth >= NSYM, pops the oldest NSYM symbols to stage 3 with a valid strobe.
- Append and pop in the same cycle are legal: new depth = depth + n - (pop ? NSYM : 0).
- If depth + n would exceed ACC_SYM after the pop: set err_overflow and drop the newest excess symbols.

Stage 3 (registered): descrambling
- Galois LFSR, polynomial x^16+x^5+x^4+x^3+1. Generates one keystream byte per symbol, combinationally unrolled NSYM times.
- Only on valid words:
  - K symbols are not XORed, but the LFSR advances on them.
  - COM at lane i reloads LFSR_SEED, so lane i+1 (or lane 0 of the next word) uses the seed value.
  - Multiple COMs in one word: the last one wins.
  - Data symbols: out = in XOR key when enable=1, else out = in.
- Invalid cycles: out_valid=0, out_data=0, out_datak=0, LFSR holds.

Latency
- 3 cycles from in_valid to out_valid when no SKP is present and the accumulator starts empty.
- With SKP present, output stalls (out_valid=0) until NSYM symbols accumulate.
- No backpressure; the sink must accept every out_valid.

Optional Feature:
USB3_RX_SKP_STATS_EN
- Defined: adds output skp_count [15:0], a saturating count of SKP symbols removed, and input skp_count_clr. skp_count_clr=1 zeroes the counter that cycle; removals that same cycle are ignored. Reset value 0.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
1. NSYM=4, enable=1: COM×4 (K=4'hF), then 8 words equal to the golden-model keystream XOR 0x00, K=0 -> out_data=32'h0 for all 8 words; first out_valid 3 cycles after first data word; no errors.
2. Word with SKP at lanes 1,2 (in_data=32'hAA3C3C55, K=4'b0110), then data words -> output stream continues in order 0x55,0xAA,... with no gap symbol; out_valid skips exactly one cycle over two such words; err_skp_split=0.
3. COM at lane 2 only (K=4'b0100), followed by zero-plaintext scrambled data -> lane 3 and all following words descramble to 0x00.
4. SKP lanes 0 and 2 (K=4'b0101, data 3C at both) -> err_skp_split=1 and sticky; remaining symbols delivered in order.
5. enable=0 with scrambled input -> out_data equals the compacted in_data unchanged. Set enable=1 mid-stream without a COM -> descrambling is correct immediately (LFSR tracked).
6. Assert reset_n=0 for 1 cycle with 3 symbols buffered -> next cycle out_valid=0, depth=0; no stale symbols ever emitted.
